id_hazard_scoreboard: RTL and testbench

Issue-side companion to the EX-stage forwarding unit in the pipelined RV32 core. Forwarding resolves dependencies whose results already sit in the MEM or WB latches. This block covers the producers that are not ready yet: loads and multi-cycle operations. It tracks every in-flight destination register with a latency countdown and raises `stall_id` to hold the ID stage until each source operand becomes forwardable. It sits beside the ID/EX pipeline register and feeds the IF/ID and ID/EX enable logic.

---
 rtl/id_hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: issue-side scoreboard for the RV32 pipeline.
// Tracks a latency countdown per destination register (x1..x31) for producers
// that are not yet forwardable (loads, multi-cycle and variable-latency ops)
// and raises stall_id until every source operand of the ID instruction is safe.
// The all-ones countdown code marks a variable-latency producer, which stays
// pending until done_valid/done_rd retires it.
// Optional feature: define SB_PERF_EN to add the 32-bit stall_cycles counter.
module id_hazard_scoreboard #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_req,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_id,
    input  logic             regWriteId,
    input  logic [CNT_W-1:0] lat_id,
    input  logic             flush,
    input  logic             hold,
    input  logic             done_valid,
    input  logic [4:0]       done_rd,
    output logic             stall_id,
    output logic             busy_var
`ifdef SB_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] LAT_VAR = '1;

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic [31:0]      pend;
    logic [31:0]      var_vec;
    logic             raw_haz;
    logic             waw_haz;
    logic             struct_haz;
    logic             issue_fire;
    logic             set_en;

    // Per-register pending / variable-latency flags; x0 is never pending.
    always_comb begin
        pend    = '0;
        var_vec = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            pend[r]    = (cnt_q[r] != '0);
            var_vec[r] = (cnt_q[r] == LAT_VAR);
        end
    end

    assign busy_var   = |var_vec;
    assign raw_haz    = pend[rs1_id] || pend[rs2_id];
    assign waw_haz    = regWriteId && (lat_id != '0) && (rd_id != 5'd0) && pend[rd_id];
    assign struct_haz = (lat_id == LAT_VAR) && busy_var;

    // Stall depends only on registered state and ID-stage inputs, never on done_*.
    assign stall_id   = issue_req && !flush && (raw_haz || waw_haz || struct_haz);
    assign issue_fire = issue_req && !stall_id && !flush && !hold;
    assign set_en     = issue_fire && regWriteId && (rd_id != 5'd0) && (lat_id != '0);

    // Next count per entry; later assignments win: issue set > completion > decrement.
    always_comb begin
        for (int unsigned r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!hold && (cnt_q[r] != '0) && (cnt_q[r] != LAT_VAR)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            if (done_valid && (done_rd == 5'(r)) && (cnt_q[r] == LAT_VAR)) begin
                cnt_d[r] = '0;
            end
            if (set_en && (rd_id == 5'(r))) begin
                cnt_d[r] = lat_id;
            end
        end
    end

    // Countdown state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef SB_PERF_EN
    logic [31:0] stall_cycles_q;

    // Count every cycle the ID stage is held by a hazard; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else if (stall_id) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed self-checking bench for id_hazard_scoreboard.
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_req;
    logic [4:0]  rs1_id, rs2_id, rd_id;
    logic        regWriteId;
    logic [2:0]  lat_id;
    logic        flush;
    logic        hold;
    logic        done_valid;
    logic [4:0]  done_rd;
    logic        stall_id;
    logic        busy_var;
`ifdef SB_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_req  (issue_req),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .rd_id      (rd_id),
        .regWriteId (regWriteId),
        .lat_id     (lat_id),
        .flush      (flush),
        .hold       (hold),
        .done_valid (done_valid),
        .done_rd    (done_rd),
        .stall_id   (stall_id),
        .busy_var   (busy_var)
`ifdef SB_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in ID, then let combinational outputs settle.
    task automatic present(input logic req, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic we, input logic [2:0] lat);
        issue_req  = req;
        rs1_id     = r1;
        rs2_id     = r2;
        rd_id      = rd;
        regWriteId = we;
        lat_id     = lat;
        #1;
    endtask

    task automatic idle();
        flush      = 1'b0;
        hold       = 1'b0;
        done_valid = 1'b0;
        done_rd    = 5'd0;
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        present(1'b1, 5'd5, 5'd9, 5'd9, 1'b1, 3'd7);
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_id);
        else pass_cnt++;
        total_cnt++;
        if (busy_var !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_var);
        else pass_cnt++;
`ifdef SB_PERF_EN
        total_cnt++;
        if (stall_cycles !== 32'd0) $display("FAIL reset_perf got=%0d exp=0", stall_cycles);
        else pass_cnt++;
`endif
        idle();
    endtask

    task automatic test_load_use();
        int n;
        present(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 3'd1);   // lw x5
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL lu_producer_stall got=%b exp=0", stall_id);
        else pass_cnt++;
        step();
        present(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 3'd0);   // add x6,x5,x1
        n = 0;
        while (stall_id && n < 20) begin step(); n++; end
        total_cnt++;
        if (n !== 1) $display("FAIL lu_bubbles got=%0d exp=1", n);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_hold();
        int n;
        present(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 3'd3);
        step();
        present(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 3'd0);
        n = 0;
        while (stall_id && n < 20) begin
            hold = (n == 1 || n == 2);
            step();
            n++;
        end
        hold = 1'b0;
        total_cnt++;
        if (n !== 5) $display("FAIL hold_stall_cycles got=%0d exp=5", n);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_variable();
        int n;
        present(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 3'd7);   // div x9
        step();
        total_cnt++;
        if (busy_var !== 1'b1) $display("FAIL var_busy_set got=%b exp=1", busy_var);
        else pass_cnt++;
        present(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 3'd7);  // second div: structural
        total_cnt++;
        if (stall_id !== 1'b1) $display("FAIL var_struct_stall got=%b exp=1", stall_id);
        else pass_cnt++;
        present(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 3'd0);  // independent add
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL var_indep_add got=%b exp=0", stall_id);
        else pass_cnt++;
        step();
        present(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 3'd7);
        step(); step(); step();
        total_cnt++;
        if (stall_id !== 1'b1) $display("FAIL var_no_countdown got=%b exp=1", stall_id);
        else pass_cnt++;
        done_valid = 1'b1;                              // aimed at an idle entry
        done_rd    = 5'd5;
        step();
        done_valid = 1'b0;
        #1;
        total_cnt++;
        if (busy_var !== 1'b1) $display("FAIL var_stray_done got=%b exp=1", busy_var);
        else pass_cnt++;
        done_valid = 1'b1;
        done_rd    = 5'd9;
        #1;
        total_cnt++;
        if (stall_id !== 1'b1) $display("FAIL var_stall_in_done_cycle got=%b exp=1", stall_id);
        else pass_cnt++;
        step();
        done_valid = 1'b0;
        #1;
        total_cnt++;
        if (busy_var !== 1'b0) $display("FAIL var_busy_clear got=%b exp=0", busy_var);
        else pass_cnt++;
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL var_div_release got=%b exp=0", stall_id);
        else pass_cnt++;
        step();                                         // div x10 issues
        present(1'b1, 5'd10, 5'd0, 5'd12, 1'b1, 3'd0);  // consumer of x10
        total_cnt++;
        if ((busy_var !== 1'b1) || (stall_id !== 1'b1))
            $display("FAIL var_raw got=%b%b exp=11", busy_var, stall_id);
        else pass_cnt++;
        step();
        done_valid = 1'b1;
        done_rd    = 5'd10;
        hold       = 1'b1;                              // completion ignores hold
        step();
        done_valid = 1'b0;
        hold       = 1'b0;
        #1;
        n = (busy_var ? 2 : 0) + (stall_id ? 1 : 0);
        total_cnt++;
        if (n !== 0) $display("FAIL var_done_under_hold got=%0d exp=0", n);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_waw_x0();
        int n;
        present(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 3'd1);   // lw x4
        step();
        present(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 3'd2);   // mul x4
        total_cnt++;
        if (stall_id !== 1'b1) $display("FAIL waw_stall got=%b exp=1", stall_id);
        else pass_cnt++;
        step();
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL waw_release got=%b exp=0", stall_id);
        else pass_cnt++;
        step();                                         // mul issues, cnt[4]=2
        present(1'b1, 5'd4, 5'd0, 5'd13, 1'b1, 3'd0);
        n = 0;
        while (stall_id && n < 20) begin step(); n++; end
        total_cnt++;
        if (n !== 2) $display("FAIL waw_mul_latency got=%0d exp=2", n);
        else pass_cnt++;
        step();
        present(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 3'd1);   // lw x0
        step();
        present(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 3'd0);
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL x0_never_pending got=%b exp=0", stall_id);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_flush();
        int n;
        present(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 3'd3);  // lw-like x12, lat 3
        step();
        flush = 1'b1;
        present(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 3'd2); // squashed dependent
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL flush_no_stall got=%b exp=0", stall_id);
        else pass_cnt++;
        step();
        flush = 1'b0;
        present(1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 3'd0);
        total_cnt++;
        if (stall_id !== 1'b0) $display("FAIL flush_no_set got=%b exp=0", stall_id);
        else pass_cnt++;
        present(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 3'd0);
        n = 0;
        while (stall_id && n < 20) begin step(); n++; end
        total_cnt++;
        if (n !== 2) $display("FAIL flush_keeps_count got=%0d exp=2", n);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        present(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 3'd7);   // div x9
        step();
        present(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'd4);   // x3, lat 4
        step();
        present(1'b1, 5'd3, 5'd9, 5'd0, 1'b0, 3'd0);
        total_cnt++;
        if ((busy_var !== 1'b1) || (stall_id !== 1'b1))
            $display("FAIL rstmid_pre got=%b%b exp=11", busy_var, stall_id);
        else pass_cnt++;
        do_reset();
        #1;
        total_cnt++;
        if ((busy_var !== 1'b0) || (stall_id !== 1'b0))
            $display("FAIL rstmid_clear got=%b%b exp=00", busy_var, stall_id);
        else pass_cnt++;
`ifdef SB_PERF_EN
        total_cnt++;
        if (stall_cycles !== 32'd0) $display("FAIL rstmid_perf got=%0d exp=0", stall_cycles);
        else pass_cnt++;
        present(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 3'd2);
        step();
        present(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 3'd0);
        step(); step(); step();
        total_cnt++;
        if (stall_cycles !== 32'd2) $display("FAIL perf_count got=%0d exp=2", stall_cycles);
        else pass_cnt++;
`endif
        idle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        test_reset();
        test_load_use();
        test_hold();
        test_variable();
        test_waw_x0();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
